// File: rtl/img_fifo_unpack.sv
// Unpacks header-framed image payload from a first-word-fall-through FIFO onto an
// AXI4-Stream master: hunts a magic header, then streams FRAME_WORDS beats with tuser/tlast.
module img_fifo_unpack #(
  parameter int          FRAME_WORDS = 65536,
  parameter logic [15:0] HDR_MAGIC   = 16'hA5C3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] fifo_rddata,
  input  logic        fifo_empty,
  output logic        fifo_rden,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [1:0]  frame_type_o,
  output logic        frame_done,
  output logic        hdr_err
);

  localparam int            CW       = $clog2(FRAME_WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic          tail;       // last payload word of the frame already popped
  logic          hdr_pop;
  logic          hdr_match;
  logic          data_pop;
  logic          accept;

  assign hdr_match = (fifo_rddata[31:16] == HDR_MAGIC);
  assign accept    = m_axis_tvalid && m_axis_tready;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    hdr_pop    = 1'b0;
    data_pop   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (enable) state_nxt = HDR;
      HDR: begin
        if (!fifo_empty) begin
          hdr_pop = 1'b1;
          if (hdr_match) state_nxt = DATA;
        end
      end
      DATA: begin
        data_pop = !fifo_empty && !tail && (!m_axis_tvalid || m_axis_tready);
        if (accept && m_axis_tlast) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Combinational outputs are forced quiet during reset so the FIFO is never drained.
    if (rst) begin
      hdr_pop    = 1'b0;
      data_pop   = 1'b0;
      frame_done = 1'b0;
    end
    fifo_rden = hdr_pop || data_pop;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: reset is synchronous; every datapath register is cleared so outputs read 0 in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      tail          <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_type_o  <= '0;
      hdr_err       <= 1'b0;
    end else begin
      hdr_err <= hdr_pop && !hdr_match;
      if (hdr_pop && hdr_match) begin
        frame_type_o <= fifo_rddata[1:0];
        count        <= '0;
        tail         <= 1'b0;
      end
      if (data_pop) begin
        m_axis_tdata  <= fifo_rddata;
        m_axis_tvalid <= 1'b1;
        m_axis_tuser  <= (count == '0);
        m_axis_tlast  <= (count == LAST_IDX);
        // Counter parks on the last index instead of wrapping; tail blocks further pops.
        if (count == LAST_IDX) tail  <= 1'b1;
        else                   count <= count + CW'(1);
      end else if (accept) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_img_fifo_unpack.sv
// Directed bench for img_fifo_unpack: a behavioural FWFT FIFO feeds the DUT and a
// scoreboard of expected beats is checked on every accepted output beat.
module tb_img_fifo_unpack;

  localparam int FW = 4;

  typedef struct packed {
    logic [31:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] fifo_rddata;
  logic        fifo_empty;
  logic        fifo_rden;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [1:0]  frame_type_o;
  logic        frame_done;
  logic        hdr_err;

  img_fifo_unpack #(.FRAME_WORDS(FW), .HDR_MAGIC(16'hA5C3)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .fifo_rddata(fifo_rddata), .fifo_empty(fifo_empty), .fifo_rden(fifo_rden),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .frame_type_o(frame_type_o),
    .frame_done(frame_done), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  // Behavioural first-word-fall-through FIFO
  logic [31:0] mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  assign fifo_empty  = (rd_ptr == wr_ptr);
  assign fifo_rddata = mem[rd_ptr[7:0]];
  always @(posedge clk) if (fifo_rden && !fifo_empty) rd_ptr <= rd_ptr + 1;

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q [$];
  int    beat_cyc [$];
  int    cyc      = 0;
  int    done_cnt = 0;
  int    err_cnt  = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  logic        hold_prev = 1'b0;
  logic [31:0] prev_d;
  logic        prev_u, prev_l;
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hdr_err)    err_cnt++;
      if (frame_done) done_cnt++;
      if (hold_prev) begin
        check("hold_tvalid", m_axis_tvalid, 1);
        check("hold_tdata", m_axis_tdata, prev_d);
        check("hold_tuser", m_axis_tuser, prev_u);
        check("hold_tlast", m_axis_tlast, prev_l);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("sb_has_entry", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tdata", m_axis_tdata, e.d);
          check("tuser", m_axis_tuser, e.u);
          check("tlast", m_axis_tlast, e.l);
          check("frame_done", frame_done, e.l);
        end
        beat_cyc.push_back(cyc);
      end else begin
        check("done_without_accept", frame_done, 0);
      end
      if (m_axis_tvalid && !m_axis_tready) check("pop_in_stall", fifo_rden, 0);
      if (fifo_rden) check("pop_when_empty", fifo_empty, 0);
      hold_prev = m_axis_tvalid && !m_axis_tready;
      prev_d    = m_axis_tdata;
      prev_u    = m_axis_tuser;
      prev_l    = m_axis_tlast;
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(logic [31:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr++;
  endtask

  task automatic expect_beat(logic [31:0] d, logic u, logic l);
    exp_q.push_back(beat_t'{d: d, u: u, l: l});
  endtask

  task automatic push_frame(logic [1:0] ty, logic [31:0] base);
    push_word({16'hA5C3, 14'd0, ty});
    for (int i = 0; i < FW; i++) begin
      push_word(base + 32'(i));
      expect_beat(base + 32'(i), (i == 0), (i == FW - 1));
    end
  endtask

  task automatic wait_done(string tag, int target, int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    check(tag, done_cnt, target);
  endtask

  task automatic wait_beat(string tag, logic [31:0] d, int budget);
    int n = 0;
    while (!(m_axis_tvalid && m_axis_tdata == d) && n < budget) begin
      step(1);
      n++;
    end
    check(tag, m_axis_tdata, d);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_rden"},   fifo_rden, 0);
    check({tag, "_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_tdata"},  m_axis_tdata, 0);
    check({tag, "_tlast"},  m_axis_tlast, 0);
    check({tag, "_tuser"},  m_axis_tuser, 0);
    check({tag, "_type"},   frame_type_o, 0);
    check({tag, "_done"},   frame_done, 0);
    check({tag, "_hdrerr"}, hdr_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    int r0;
    int n;
    rst           = 1'b1;
    enable        = 1'b0;
    m_axis_tready = 1'b1;
    step(2);
    @(negedge clk);
    check_all_zero("reset");
    step(1);
    rst    = 1'b0;
    enable = 1'b1;

    // Basic frame at full throughput
    push_frame(2'd2, 32'd1);
    wait_done("t1_done", 1, 50);
    check("t1_type", frame_type_o, 2);
    n = beat_cyc.size();
    check("t1_consecutive", beat_cyc[n-1] - beat_cyc[n-4], 3);
    check("t1_hdr_err", err_cnt, 0);

    // Backpressure on beat 2 for three cycles
    push_frame(2'd1, 32'h100);
    wait_beat("t2_beat2", 32'h101, 50);
    m_axis_tready = 1'b0;
    r0 = rd_ptr;
    step(3);
    check("t2_no_pop_held", rd_ptr, r0);
    m_axis_tready = 1'b1;
    wait_done("t2_done", 2, 50);
    check("t2_type", frame_type_o, 1);

    // Garbage word ahead of the header
    e0 = err_cnt;
    push_word(32'h12345678);
    push_frame(2'd3, 32'h200);
    wait_done("t3_done", 3, 50);
    check("t3_hdr_err", err_cnt - e0, 1);
    check("t3_type", frame_type_o, 3);

    // FIFO runs dry after beat 2 for five cycles
    push_word({16'hA5C3, 16'h0000});
    push_word(32'h300); expect_beat(32'h300, 1'b1, 1'b0);
    push_word(32'h301); expect_beat(32'h301, 1'b0, 1'b0);
    wait_beat("t4_beat2", 32'h301, 50);
    step(1);
    for (int i = 0; i < 5; i++) begin
      check("t4_gap_tvalid", m_axis_tvalid, 0);
      step(1);
    end
    push_word(32'h302); expect_beat(32'h302, 1'b0, 1'b0);
    push_word(32'h303); expect_beat(32'h303, 1'b0, 1'b1);
    wait_done("t4_done", 4, 50);
    check("t4_type", frame_type_o, 0);

    // enable dropped mid-frame: frame completes, next header waits for enable
    push_frame(2'd1, 32'h400);
    wait_beat("t5_beat1", 32'h400, 50);
    enable = 1'b0;
    wait_done("t5_done", 5, 50);
    r0 = rd_ptr;
    push_frame(2'd2, 32'h500);
    step(10);
    check("t5_no_hdr_pop", rd_ptr, r0);
    enable = 1'b1;
    wait_done("t5_done2", 6, 50);
    check("t5_type", frame_type_o, 2);

    // Reset mid-frame after beat 2, leftovers hunted away
    push_word({16'hA5C3, 16'h0003});
    push_word(32'h600); expect_beat(32'h600, 1'b1, 1'b0);
    push_word(32'h601); expect_beat(32'h601, 1'b0, 1'b0);
    wait_beat("t6_beat2", 32'h601, 50);
    step(1);
    push_word(32'h602);
    push_word(32'h603);
    rst = 1'b1;
    e0  = err_cnt;
    @(negedge clk);
    check("t6_rden_in_rst", fifo_rden, 0);
    step(1);
    check_all_zero("t6_rst");
    check("t6_no_drain", wr_ptr - rd_ptr, 2);
    rst = 1'b0;
    push_frame(2'd1, 32'h700);
    wait_done("t6_done", 7, 80);
    check("t6_hdr_err", err_cnt - e0, 2);
    check("t6_type", frame_type_o, 1);
    check("fifo_drained", wr_ptr - rd_ptr, 0);

    step(2);
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
